// File: rtl/ddr5_phy_pkg.sv
// Shared types and helpers for the DDR5 PHY write path: FSM states, DQS
// encodings and the CRC-8 (poly 0x07) update used on the write burst.
package ddr5_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_CRC,
        ST_POST
    } wr_state_e;

    localparam logic [1:0] DQS_STATIC = 2'b00;
    localparam logic [1:0] DQS_TOGGLE = 2'b01;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Bit-serial CRC-8 over the low nbits of data, bit 0 shifted in first.
    function automatic logic [7:0] crc8_update(input logic [7:0]  crc,
                                               input logic [31:0] data,
                                               input int          nbits);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                fb = c[7] ^ data[i];
                c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ddr5_phy_wr_fifo.sv
// Show-ahead synchronous FIFO for the write-data path; the head entry is
// visible on pop_data_o whenever empty_o is low. pDEPTH must be a power of 2.
module ddr5_phy_wr_fifo #(
    parameter int pWIDTH = 18,
    parameter int pDEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [pWIDTH-1:0] push_data_i,
    input  logic              pop_i,
    output logic [pWIDTH-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int          AW         = $clog2(pDEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(pDEPTH);

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full_o     = (count_q == FULL_COUNT);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    // NOTE: non-blocking assignments in clocked blocks keep flop updates order-independent.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ddr5_phy_wr_burst_gen.sv
// DDR5 PHY write burst generator: preamble, data beats from a FIFO, optional
// CRC beat and postamble. CRC beat is built only with DDR5_PHY_WR_CRC_EN.
module ddr5_phy_wr_burst_gen
    import ddr5_phy_pkg::*;
#(
    parameter int pDRAM_SIZE  = 8,
    parameter int pFIFO_DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      cfg_bl16_i,
    input  logic [1:0]                cfg_pre_i,
    input  logic                      cfg_post_i,
    input  logic                      cmd_start_i,
    input  logic                      wr_valid_i,
    input  logic [2*pDRAM_SIZE-1:0]   wr_data_i,
    input  logic [pDRAM_SIZE/4-1:0]   wr_mask_i,
    output logic                      wr_ready_o,
    output logic [2*pDRAM_SIZE-1:0]   DQ,
    output logic [pDRAM_SIZE/4-1:0]   DM,
    output logic                      DQ_valid,
    output logic [1:0]                DQS,
    output logic                      DQS_valid,
    output logic                      underrun_o,
    output logic                      overlap_o
);

    localparam int DW = 2 * pDRAM_SIZE;
    localparam int MW = pDRAM_SIZE / 4;

    wr_state_e        state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             bl16_q, bl16_d;
    logic [1:0]       pre_q, pre_d;
    logic             post_q, post_d;
    logic             overlap_q, overlap_d;
    logic             cmd_hit, accept;
    logic [2:0]       data_last;

    logic [MW+DW-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop;

    assign wr_ready_o = !fifo_full;
    assign overlap_o  = overlap_q;

    ddr5_phy_wr_fifo #(
        .pWIDTH(MW + DW),
        .pDEPTH(pFIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (wr_valid_i && wr_ready_o),
        .push_data_i({wr_mask_i, wr_data_i}),
        .pop_i      (fifo_pop),
        .pop_data_o (fifo_rdata),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

`ifdef DDR5_PHY_WR_CRC_EN
    logic [7:0]    crc_q, crc_d;
    logic [DW-1:0] crc_dq;

    // Unused high-beat lanes carry all ones on the CRC beat.
    if (pDRAM_SIZE == 4) begin : g_crc_x4
        assign crc_dq = crc_q;
    end else if (pDRAM_SIZE == 8) begin : g_crc_x8
        assign crc_dq = {8'hFF, crc_q};
    end else begin : g_crc_x16
        assign crc_dq = {16'hFFFF, crc_q, crc_q};
    end
`endif

    assign cmd_hit   = cmd_start_i && enable_i;
    assign accept    = cmd_hit && (state_q == ST_IDLE || state_q == ST_POST);
    assign data_last = bl16_q ? 3'd7 : 3'd3;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bl16_d     = bl16_q;
        pre_d      = pre_q;
        post_d     = post_q;
        overlap_d  = cmd_hit && !accept;
        fifo_pop   = 1'b0;
        DQ         = '0;
        DM         = '0;
        DQ_valid   = 1'b0;
        DQS        = DQS_STATIC;
        DQS_valid  = 1'b0;
        underrun_o = 1'b0;
`ifdef DDR5_PHY_WR_CRC_EN
        crc_d      = crc_q;
`endif

        unique case (state_q)
            ST_IDLE: ;
            ST_PRE: begin
                DQS_valid = 1'b1;
                if (cnt_q == {1'b0, pre_q}) begin
                    DQS     = DQS_TOGGLE;
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            ST_DATA: begin
                DQS_valid = 1'b1;
                DQS       = DQS_TOGGLE;
                DQ_valid  = 1'b1;
                // An empty FIFO still consumes a beat so the burst length is fixed.
                if (fifo_empty) begin
                    DQ         = '0;
                    DM         = '1;
                    underrun_o = 1'b1;
                end else begin
                    fifo_pop = 1'b1;
                    {DM, DQ} = fifo_rdata;
                end
`ifdef DDR5_PHY_WR_CRC_EN
                crc_d = crc8_update(crc_q, 32'(DQ), DW);
`endif
                if (cnt_q == data_last) begin
                    cnt_d = '0;
`ifdef DDR5_PHY_WR_CRC_EN
                    state_d = ST_CRC;
`else
                    state_d = ST_POST;
`endif
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_CRC: begin
`ifdef DDR5_PHY_WR_CRC_EN
                DQS_valid = 1'b1;
                DQS       = DQS_TOGGLE;
                DQ_valid  = 1'b1;
                DQ        = crc_dq;
                state_d   = ST_POST;
`else
                state_d   = ST_IDLE;
`endif
            end
            ST_POST: begin
                DQS_valid = 1'b1;
                if (cnt_q == {2'b00, post_q}) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Configuration is captured only here, so mid-burst cfg changes are inert.
        if (accept) begin
            state_d = ST_PRE;
            cnt_d   = '0;
            bl16_d  = cfg_bl16_i;
            pre_d   = cfg_pre_i;
            post_d  = cfg_post_i;
`ifdef DDR5_PHY_WR_CRC_EN
            crc_d   = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bl16_q    <= 1'b0;
            pre_q     <= '0;
            post_q    <= 1'b0;
            overlap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bl16_q    <= bl16_d;
            pre_q     <= pre_d;
            post_q    <= post_d;
            overlap_q <= overlap_d;
        end
    end

`ifdef DDR5_PHY_WR_CRC_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) crc_q <= 8'h00;
        else       crc_q <= crc_d;
    end
`endif

endmodule

// File: tb/tb_ddr5_phy_wr_burst_gen.sv
// Scoreboard bench for ddr5_phy_wr_burst_gen (x8, 8-entry FIFO); the expected
// CRC beat is included when DDR5_PHY_WR_CRC_EN is defined.
module tb_ddr5_phy_wr_burst_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        cfg_bl16_i;
    logic [1:0]  cfg_pre_i;
    logic        cfg_post_i;
    logic        cmd_start_i;
    logic        wr_valid_i;
    logic [15:0] wr_data_i;
    logic [1:0]  wr_mask_i;
    logic        wr_ready_o;
    logic [15:0] DQ;
    logic [1:0]  DM;
    logic        DQ_valid;
    logic [1:0]  DQS;
    logic        DQS_valid;
    logic        underrun_o;
    logic        overlap_o;

    int n_total = 0;
    int n_bad   = 0;

    logic [23:0] exp_q[$];
    logic [17:0] mdl_q[$];
    logic [23:0] obs_vec;

    ddr5_phy_wr_burst_gen #(
        .pDRAM_SIZE (8),
        .pFIFO_DEPTH(8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .cfg_bl16_i (cfg_bl16_i),
        .cfg_pre_i  (cfg_pre_i),
        .cfg_post_i (cfg_post_i),
        .cmd_start_i(cmd_start_i),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_mask_i  (wr_mask_i),
        .wr_ready_o (wr_ready_o),
        .DQ         (DQ),
        .DM         (DM),
        .DQ_valid   (DQ_valid),
        .DQS        (DQS),
        .DQS_valid  (DQS_valid),
        .underrun_o (underrun_o),
        .overlap_o  (overlap_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs_vec = {overlap_o, underrun_o, DQS_valid, DQS, DQ_valid, DM, DQ};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [23:0] mk(input logic ov, input logic ur, input logic sv,
                                       input logic [1:0] s, input logic dv,
                                       input logic [1:0] m, input logic [15:0] d);
        return {ov, ur, sv, s, dv, m, d};
    endfunction

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [15:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 16; i++) begin
            if (r[7] ^ d[i]) r = (r << 1) ^ 8'h07;
            else             r = r << 1;
        end
        return r;
    endfunction

    // Every cycle's outputs are checked; an empty scoreboard means idle outputs.
    always @(negedge clk_i) begin
        logic [23:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'h0;
        check("cycle", {8'h0, obs_vec}, {8'h0, e});
    end

    task automatic write_word(input logic [15:0] d, input logic [1:0] m);
        check("ready_before_write", {31'h0, wr_ready_o}, 32'h1);
        wr_valid_i = 1'b1;
        wr_data_i  = d;
        wr_mask_i  = m;
        mdl_q.push_back({m, d});
        @(posedge clk_i); #1;
        wr_valid_i = 1'b0;
    endtask

    task automatic fill_to(input int n);
        while (mdl_q.size() < n) write_word(16'($urandom), 2'($urandom));
    endtask

    task automatic start_burst(input logic bl16, input logic [1:0] pre, input logic post);
        logic [7:0]  crc;
        logic [17:0] w;
        crc         = 8'h00;
        cfg_bl16_i  = bl16;
        cfg_pre_i   = pre;
        cfg_post_i  = post;
        cmd_start_i = 1'b1;
        @(negedge clk_i); #1;
        for (int p = 0; p <= int'(pre); p++)
            exp_q.push_back(mk(0, 0, 1, (p == int'(pre)) ? 2'b01 : 2'b00, 0, 2'b00, 16'h0));
        for (int i = 0; i < (bl16 ? 8 : 4); i++) begin
            if (mdl_q.size() > 0) begin
                w = mdl_q.pop_front();
                exp_q.push_back(mk(0, 0, 1, 2'b01, 1, w[17:16], w[15:0]));
                crc = crc_step(crc, w[15:0]);
            end else begin
                exp_q.push_back(mk(0, 1, 1, 2'b01, 1, 2'b11, 16'h0));
                crc = crc_step(crc, 16'h0);
            end
        end
`ifdef DDR5_PHY_WR_CRC_EN
        exp_q.push_back(mk(0, 0, 1, 2'b01, 1, 2'b00, {8'hFF, crc}));
`endif
        for (int p = 0; p <= int'(post); p++)
            exp_q.push_back(mk(0, 0, 1, 2'b00, 0, 2'b00, 16'h0));
        @(posedge clk_i); #1;
        cmd_start_i = 1'b0;
        cfg_bl16_i  = ~bl16;
        cfg_pre_i   = ~pre;
        cfg_post_i  = ~post;
    endtask

    task automatic wait_until_left(input int left);
        int budget;
        budget = 200;
        while (exp_q.size() > left && budget > 0) begin
            @(posedge clk_i); #1;
            budget--;
        end
        if (exp_q.size() > left) begin
            check("wait_timeout", exp_q.size(), left);
            exp_q.delete();
        end
    endtask

    task automatic wait_idle();
        wait_until_left(0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        enable_i    = 1'b1;
        cfg_bl16_i  = 1'b0;
        cfg_pre_i   = 2'd0;
        cfg_post_i  = 1'b0;
        cmd_start_i = 1'b0;
        wr_valid_i  = 1'b0;
        wr_data_i   = '0;
        wr_mask_i   = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_ready", {31'h0, wr_ready_o}, 32'h1);
        check("reset_outputs", {8'h0, obs_vec}, 32'h0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // BL16, 2-cycle preamble, 1-cycle postamble, full data
        fill_to(8);
        start_burst(1'b1, 2'd1, 1'b0);
        wait_idle();

        // BL8 with all-zero data
        for (int i = 0; i < 4; i++) write_word(16'h0000, 2'b00);
        start_burst(1'b0, 2'd0, 1'b0);
        wait_idle();

        // BL16 with only five words buffered: three underrun beats
        fill_to(5);
        start_burst(1'b1, 2'd2, 1'b1);
        wait_idle();

        // back-to-back: second command in the last postamble cycle
        fill_to(8);
        start_burst(1'b0, 2'd0, 1'b1);
        wait_until_left(1);
        start_burst(1'b0, 2'd3, 1'b0);
        wait_idle();

        // overlapping command during DATA is ignored and flagged
        fill_to(8);
        start_burst(1'b0, 2'd0, 1'b0);
        @(posedge clk_i); #1;
        cmd_start_i = 1'b1;
        cfg_bl16_i  = 1'b1;
        @(negedge clk_i); #1;
        exp_q[0] = exp_q[0] | 24'h800000;
        @(posedge clk_i); #1;
        cmd_start_i = 1'b0;
        wait_idle();

        // full FIFO drops a further write; one pop frees a slot next cycle
        fill_to(8);
        check("full_ready", {31'h0, wr_ready_o}, 32'h0);
        wr_valid_i = 1'b1;
        wr_data_i  = 16'hDEAD;
        wr_mask_i  = 2'b01;
        @(posedge clk_i); #1;
        wr_valid_i = 1'b0;
        check("full_ready_hold", {31'h0, wr_ready_o}, 32'h0);
        start_burst(1'b0, 2'd0, 1'b1);
        check("ready_in_pre", {31'h0, wr_ready_o}, 32'h0);
        @(posedge clk_i); #1;
        check("ready_first_pop", {31'h0, wr_ready_o}, 32'h0);
        @(posedge clk_i); #1;
        check("ready_after_pop", {31'h0, wr_ready_o}, 32'h1);
        wait_idle();
        start_burst(1'b0, 2'd1, 1'b0);
        wait_idle();

        // commands are ignored while the block is disabled
        enable_i    = 1'b0;
        cmd_start_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_start_i = 1'b0;
        enable_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        // reset in the middle of DATA, then a clean burst
        fill_to(8);
        start_burst(1'b1, 2'd0, 1'b0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        exp_q.delete();
        mdl_q.delete();
        #1;
        check("reset_mid_outputs", {8'h0, obs_vec}, 32'h0);
        check("reset_mid_ready", {31'h0, wr_ready_o}, 32'h1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        fill_to(8);
        start_burst(1'b1, 2'd1, 1'b1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
